reg_file_initiator: RTL and testbench
=====================================

Name: reg_file_initiator

Overview:
- Master-side controller that drives the 32-entry x 32-bit register file: two read ports, one write port, plus `read_sel` and `write_sel` strobes.
- Converts an upstream operand-read request channel and a write-back channel into register-file port activity.
- Returns read results through a valid/ready response channel.
- Handles same-cycle write/read ordering and hardwired register 0.
- Sits between decode/writeback logic and `register_file_32`.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH entries)
- ZERO_REG_EN, 1, when 1 register 0 reads as 0 and writes to it are dropped

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_req_valid  in  1  operand read request valid
- rd_req_ready  out  1  request accepted when valid&ready
- rd_req_src1  in  ADDR_WIDTH  first source index
- rd_req_src2  in  ADDR_WIDTH  second source index
- rd_rsp_valid  out  1  response data valid
- rd_rsp_ready  in  1  response consumed when valid&ready
- rd_rsp_data1  out  DATA_WIDTH  value of src1
- rd_rsp_data2  out  DATA_WIDTH  value of src2
- wb_valid  in  1  write-back valid
- wb_ready  out  1  write-back accepted when valid&ready
- wb_dest  in  ADDR_WIDTH  destination index
- wb_data  in  DATA_WIDTH  write data
- rf_sel1  out  ADDR_WIDTH  to register file `sel1`
- rf_sel2  out  ADDR_WIDTH  to register file `sel2`
- rf_sel_write  out  ADDR_WIDTH  to register file `sel_write`
- rf_data_write  out  DATA_WIDTH  to register file `data_write`
- rf_read_sel  out  1  read strobe
- rf_write_sel  out  1  write strobe
- rf_data_read1  in  DATA_WIDTH  from register file port 1
- rf_data_read2  in  DATA_WIDTH  from register file port 2

Behaviour:
- Register-file contract: on the rising clk edge with `rf_read_sel`=1, the file samples `rf_sel1`/`rf_sel2`. `rf_data_read1`/`rf_data_read2` are valid throughout the following cycle. A write with `rf_write_sel`=1 commits at the same edge. A same-edge read returns the OLD value.
- Reset (async assert, sync release): state=IDLE; `rd_req_ready`=0, `rd_rsp_valid`=0, `rd_rsp_data1`/`rd_rsp_data2`=0, `wb_ready`=0; all rf_* outputs 0. On the first clk edge after release: `wb_ready`=1 and `rd_req_ready`=1, held thereafter.
- Write path (combinational, zero latency):
  - `rf_write_sel` = `wb_valid & wb_ready & ~(ZERO_REG_EN & wb_dest==0)`.
  - `rf_sel_write`=`wb_dest`, `rf_data_write`=`wb_data` while `wb_valid`, else 0.
  - A write to register 0 is accepted (handshake completes) but not issued.
- Read FSM, states IDLE, ISSUE, CAPTURE, RESP:
  - IDLE: `rd_req_ready`=1. On `rd_req_valid`: latch src1/src2 into `rf_sel1`/`rf_sel2` -> ISSUE.
  - ISSUE (1 cycle): `rf_read_sel`=1, `rd_req_ready`=0. Record per port whether an accepted, non-dropped write this cycle targets src1/src2, and its data -> CAPTURE.
  - CAPTURE (1 cycle): load `rd_rsp_data1`/`rd_rsp_data2`, each with priority:
    1. Zero: ZERO_REG_EN and src==0 gives 0.
    2. Forward: the write recorded in ISSUE gives that wb_data.
    3. Otherwise `rf_data_read`.
    Then -> RESP.
  - RESP: `rd_rsp_valid`=1, data stable. On `rd_rsp_ready` -> IDLE. The next request is accepted no earlier than the following cycle.
- Latency: request accept to `rd_rsp_valid` is 3 edges. Throughput is one request per 4 cycles with `rd_rsp_ready` tied high.
- Snapshot semantics: writes during CAPTURE or RESP do not alter a pending response.
- Writes are never back-pressured by the read FSM; both channels may fire in the same cycle.
- src1==src2: both outputs carry the same resolved value.
- `rf_sel1`/`rf_sel2` hold their last value outside ISSUE. `rf_read_sel` is 0 outside ISSUE.
- Reset mid-operation: the FSM returns to IDLE, any pending response is discarded, and `rd_rsp_valid` drops immediately.

Decomposition:
- Package `rf_if_pkg`:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - State encoding: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2, RESP=2'd3.
  - Zero-register index constant.
- Sub-module `rf_fwd_mux`: per-port zero/forward/file select, instantiated twice.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> all outputs 0 during reset; `wb_ready`=1 and `rd_req_ready`=1 one edge after release.
- Write then read: wb write 5<-32'h19, later read src1=5, src2=26 (26 preloaded 32'h2A4) -> `rd_rsp_data1`=32'h19, `rd_rsp_data2`=32'h2A4, `rd_rsp_valid` 3 edges after accept.
- Forwarding: reg 7 holds 32'h31; in the ISSUE cycle of a read of src1=7, wb writes 7<-32'hDEAD -> `rd_rsp_data1`=32'hDEAD. A write 7<-32'hBEEF during CAPTURE -> response still 32'hDEAD.
- Register 0: wb write 0<-32'hFFFF_FFFF -> `wb_ready` handshake completes, `rf_write_sel`=0; read src1=0, src2=0 -> both 0.
- Back-pressure: hold `rd_rsp_ready`=0 for 5 cycles in RESP while writing the source register -> data stable, `rd_req_ready`=0 throughout; raise ready -> IDLE next cycle.
- Reset mid-read: assert rst_n=0 during CAPTURE -> `rd_rsp_valid` stays 0, FSM in IDLE after release; a new read of reg 3 returns the file value.

Source files
------------

// File: rtl/rf_if_pkg.sv
// Shared definitions for the register-file initiator and its operand muxes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rf_if_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    // Index of the hardwired-zero register.
    localparam int RF_ZERO_REG = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } rd_state_e;

endpackage

// File: rtl/rf_fwd_mux.sv
// Resolves one operand: the hardwired zero wins, then a forwarded write, then the file data.
// Latency: purely combinational.
// Backpressure: none; the caller samples the output when it needs it.
module rf_fwd_mux
    import rf_if_pkg::*;
#(
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = RF_ADDR_WIDTH,
    parameter int ZERO_REG_EN = 1
) (
    input  logic [ADDR_WIDTH-1:0] sel_i,
    input  logic                  fwd_vld_i,
    input  logic [DATA_WIDTH-1:0] fwd_dat_i,
    input  logic [DATA_WIDTH-1:0] rf_dat_i,
    output logic [DATA_WIDTH-1:0] dat_o
);

    // Priority select: zero register, then same-edge write, then stored value.
    always_comb begin
        dat_o = rf_dat_i;
        if ((ZERO_REG_EN != 0) && (sel_i == ADDR_WIDTH'(RF_ZERO_REG))) begin
            dat_o = '0;
        end else if (fwd_vld_i) begin
            dat_o = fwd_dat_i;
        end
    end

endmodule

// File: rtl/reg_file_initiator.sv
// Drives a 2R/1W register file from an operand-read request channel and a write-back channel.
// Latency: read accept to response valid on the third edge (IDLE/ISSUE/CAPTURE/RESP); writes are zero latency.
// Backpressure: response held stable until rd_rsp_ready; writes are never stalled by the read FSM.
module reg_file_initiator
    import rf_if_pkg::*;
#(
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = RF_ADDR_WIDTH,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_src1,
    input  logic [ADDR_WIDTH-1:0] rd_req_src2,
    output logic                  rd_rsp_valid,
    input  logic                  rd_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd_rsp_data1,
    output logic [DATA_WIDTH-1:0] rd_rsp_data2,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] rf_sel1,
    output logic [ADDR_WIDTH-1:0] rf_sel2,
    output logic [ADDR_WIDTH-1:0] rf_sel_write,
    output logic [DATA_WIDTH-1:0] rf_data_write,
    output logic                  rf_read_sel,
    output logic                  rf_write_sel,
    input  logic [DATA_WIDTH-1:0] rf_data_read1,
    input  logic [DATA_WIDTH-1:0] rf_data_read2
);

    rd_state_e             state_q, state_d;
    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] sel1_q, sel1_d, sel2_q, sel2_d;
    logic                  fwd1_vld_q, fwd1_vld_d, fwd2_vld_q, fwd2_vld_d;
    logic [DATA_WIDTH-1:0] fwd1_dat_q, fwd1_dat_d, fwd2_dat_q, fwd2_dat_d;
    logic [DATA_WIDTH-1:0] rsp1_q, rsp1_d, rsp2_q, rsp2_d;
    logic [DATA_WIDTH-1:0] mux1_dat, mux2_dat;
    logic                  wb_to_zero;
    logic                  wb_fire;
    logic                  wr_issue;

    // Write path: a write to the zero register completes its handshake but never reaches the file.
    assign wb_ready      = ready_q;
    assign wb_fire       = wb_valid & ready_q;
    assign wb_to_zero    = (ZERO_REG_EN != 0) && (wb_dest == ADDR_WIDTH'(RF_ZERO_REG));
    assign wr_issue      = wb_fire & ~wb_to_zero;
    assign rf_write_sel  = wr_issue;
    assign rf_sel_write  = wb_fire ? wb_dest : '0;
    assign rf_data_write = wb_fire ? wb_data : '0;

    assign rf_sel1      = sel1_q;
    assign rf_sel2      = sel2_q;
    assign rd_rsp_data1 = rsp1_q;
    assign rd_rsp_data2 = rsp2_q;

    // State and datapath registers; reset also discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            sel1_q     <= '0;
            sel2_q     <= '0;
            fwd1_vld_q <= 1'b0;
            fwd2_vld_q <= 1'b0;
            fwd1_dat_q <= '0;
            fwd2_dat_q <= '0;
            rsp1_q     <= '0;
            rsp2_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            fwd1_vld_q <= fwd1_vld_d;
            fwd2_vld_q <= fwd2_vld_d;
            fwd1_dat_q <= fwd1_dat_d;
            fwd2_dat_q <= fwd2_dat_d;
            rsp1_q     <= rsp1_d;
            rsp2_q     <= rsp2_d;
        end
    end

    // Read FSM: next state, captured operands and handshake outputs.
    always_comb begin
        state_d      = state_q;
        sel1_d       = sel1_q;
        sel2_d       = sel2_q;
        fwd1_vld_d   = fwd1_vld_q;
        fwd2_vld_d   = fwd2_vld_q;
        fwd1_dat_d   = fwd1_dat_q;
        fwd2_dat_d   = fwd2_dat_q;
        rsp1_d       = rsp1_q;
        rsp2_d       = rsp2_q;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rf_read_sel  = 1'b0;
        case (state_q)
            IDLE: begin
                rd_req_ready = ready_q;
                if (rd_req_valid && ready_q) begin
                    sel1_d  = rd_req_src1;
                    sel2_d  = rd_req_src2;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The file returns the pre-write value for a same-edge write, so remember it here.
                rf_read_sel = 1'b1;
                fwd1_vld_d  = wr_issue && (wb_dest == sel1_q);
                fwd2_vld_d  = wr_issue && (wb_dest == sel2_q);
                fwd1_dat_d  = wb_data;
                fwd2_dat_d  = wb_data;
                state_d     = CAPTURE;
            end
            CAPTURE: begin
                rsp1_d  = mux1_dat;
                rsp2_d  = mux2_dat;
                state_d = RESP;
            end
            RESP: begin
                rd_rsp_valid = 1'b1;
                if (rd_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    rf_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG_EN(ZERO_REG_EN)
    ) u_mux1 (
        .sel_i    (sel1_q),
        .fwd_vld_i(fwd1_vld_q),
        .fwd_dat_i(fwd1_dat_q),
        .rf_dat_i (rf_data_read1),
        .dat_o    (mux1_dat)
    );

    rf_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG_EN(ZERO_REG_EN)
    ) u_mux2 (
        .sel_i    (sel2_q),
        .fwd_vld_i(fwd2_vld_q),
        .fwd_dat_i(fwd2_dat_q),
        .rf_dat_i (rf_data_read2),
        .dat_o    (mux2_dat)
    );

endmodule

// File: tb/tb_reg_file_initiator.sv
// Directed bench: behavioural register file behind the DUT, table of writes and reads.
// Latency: reads checked cycle by cycle through ISSUE/CAPTURE/RESP.
// Backpressure: response hold and mid-read reset exercised by hand-written sequences.
module tb_reg_file_initiator;

    logic        clk;
    logic        rst_n;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [4:0]  rd_req_src1, rd_req_src2;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [31:0] rd_rsp_data1, rd_rsp_data2;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic [4:0]  rf_sel1, rf_sel2, rf_sel_write;
    logic [31:0] rf_data_write;
    logic        rf_read_sel, rf_write_sel;
    logic [31:0] rf_data_read1, rf_data_read2;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_initiator #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .ZERO_REG_EN(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_src1  (rd_req_src1),
        .rd_req_src2  (rd_req_src2),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data1 (rd_rsp_data1),
        .rd_rsp_data2 (rd_rsp_data2),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .rf_sel1      (rf_sel1),
        .rf_sel2      (rf_sel2),
        .rf_sel_write (rf_sel_write),
        .rf_data_write(rf_data_write),
        .rf_read_sel  (rf_read_sel),
        .rf_write_sel (rf_write_sel),
        .rf_data_read1(rf_data_read1),
        .rf_data_read2(rf_data_read2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: same-edge read sees old data; index 0 returns junk so zeroing is the DUT's job.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (rf_write_sel) mem[rf_sel_write] <= rf_data_write;
        if (rf_read_sel) begin
            rf_data_read1 <= (rf_sel1 == 5'd0) ? 32'hBAD0_0000 : mem[rf_sel1];
            rf_data_read2 <= (rf_sel2 == 5'd0) ? 32'hBAD0_0000 : mem[rf_sel2];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_vec_t;

    typedef struct {
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        wi_en;
        logic [4:0]  wi_dest;
        logic [31:0] wi_data;
        logic        wc_en;
        logic [4:0]  wc_dest;
        logic [31:0] wc_data;
        int          hold;
        logic [31:0] e1;
        logic [31:0] e2;
    } rd_vec_t;

    // Called at #1 after a posedge with the DUT idle.
    task automatic do_write(input wr_vec_t w);
        wb_valid = 1'b1;
        wb_dest  = w.dest;
        wb_data  = w.data;
        #1;
        check($sformatf("wr%0d wb_ready", w.dest), {31'd0, wb_ready}, 32'd1);
        check($sformatf("wr%0d write_sel", w.dest), {31'd0, rf_write_sel}, {31'd0, (w.dest != 5'd0)});
        check($sformatf("wr%0d sel_write", w.dest), {27'd0, rf_sel_write}, {27'd0, w.dest});
        check($sformatf("wr%0d data_write", w.dest), rf_data_write, w.data);
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    // Called at #1 after a posedge with the DUT idle; walks one read through every state.
    task automatic do_read(input rd_vec_t v, input int idx);
        rd_req_valid = 1'b1;
        rd_req_src1  = v.s1;
        rd_req_src2  = v.s2;
        #1;
        check($sformatf("rd%0d req_ready idle", idx), {31'd0, rd_req_ready}, 32'd1);
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        check($sformatf("rd%0d issue read_sel", idx), {31'd0, rf_read_sel}, 32'd1);
        check($sformatf("rd%0d issue sel1", idx), {27'd0, rf_sel1}, {27'd0, v.s1});
        check($sformatf("rd%0d issue sel2", idx), {27'd0, rf_sel2}, {27'd0, v.s2});
        check($sformatf("rd%0d issue req_ready", idx), {31'd0, rd_req_ready}, 32'd0);
        if (v.wi_en) begin
            wb_valid = 1'b1; wb_dest = v.wi_dest; wb_data = v.wi_data;
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        check($sformatf("rd%0d capture rsp_valid", idx), {31'd0, rd_rsp_valid}, 32'd0);
        check($sformatf("rd%0d capture read_sel", idx), {31'd0, rf_read_sel}, 32'd0);
        if (v.wc_en) begin
            wb_valid = 1'b1; wb_dest = v.wc_dest; wb_data = v.wc_data;
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        check($sformatf("rd%0d latency rsp_valid", idx), {31'd0, rd_rsp_valid}, 32'd1);
        check($sformatf("rd%0d data1", idx), rd_rsp_data1, v.e1);
        check($sformatf("rd%0d data2", idx), rd_rsp_data2, v.e2);
        for (int i = 0; i < v.hold; i++) begin
            wb_valid = 1'b1; wb_dest = v.s1; wb_data = 32'hAAAA_0000 + i;
            @(posedge clk); #1;
            check($sformatf("rd%0d hold%0d rsp_valid", idx, i), {31'd0, rd_rsp_valid}, 32'd1);
            check($sformatf("rd%0d hold%0d req_ready", idx, i), {31'd0, rd_req_ready}, 32'd0);
            check($sformatf("rd%0d hold%0d data1", idx, i), rd_rsp_data1, v.e1);
            check($sformatf("rd%0d hold%0d data2", idx, i), rd_rsp_data2, v.e2);
        end
        wb_valid     = 1'b0;
        rd_rsp_ready = 1'b1;
        @(posedge clk); #1;
        rd_rsp_ready = 1'b0;
        check($sformatf("rd%0d done rsp_valid", idx), {31'd0, rd_rsp_valid}, 32'd0);
        check($sformatf("rd%0d done req_ready", idx), {31'd0, rd_req_ready}, 32'd1);
    endtask

    wr_vec_t wvecs [5];
    rd_vec_t rvecs [7];
    rd_vec_t rv;

    initial begin
        // Preload writes; the write to register 0 completes but must not reach the file.
        wvecs[0] = '{5'd5,  32'h0000_0019};
        wvecs[1] = '{5'd26, 32'h0000_02A4};
        wvecs[2] = '{5'd7,  32'h0000_0031};
        wvecs[3] = '{5'd3,  32'h00C0_FFEE};
        wvecs[4] = '{5'd0,  32'hFFFF_FFFF};

        // s1, s2, issue-write, capture-write, hold cycles, expected data1/data2
        rvecs[0] = '{5'd5,  5'd26, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         0, 32'h19,   32'h2A4};
        rvecs[1] = '{5'd7,  5'd5,  1'b1, 5'd7, 32'hDEAD,      1'b1, 5'd7, 32'hBEEF,      0, 32'hDEAD, 32'h19};
        rvecs[2] = '{5'd7,  5'd7,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         0, 32'hBEEF, 32'hBEEF};
        rvecs[3] = '{5'd0,  5'd0,  1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,         0, 32'h0,    32'h0};
        rvecs[4] = '{5'd26, 5'd3,  1'b1, 5'd3, 32'h1234,      1'b0, 5'd0, 32'h0,         0, 32'h2A4,  32'h1234};
        rvecs[5] = '{5'd3,  5'd3,  1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 32'h5555,      0, 32'h1234, 32'h1234};
        rvecs[6] = '{5'd5,  5'd26, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5, 32'h19,   32'h2A4};

        rst_n        = 1'b0;
        rd_req_valid = 1'b0;
        rd_req_src1  = '0;
        rd_req_src2  = '0;
        rd_rsp_ready = 1'b0;
        wb_valid     = 1'b0;
        wb_dest      = '0;
        wb_data      = '0;

        // Reset held for three cycles, everything quiet.
        repeat (3) @(posedge clk);
        #1;
        check("rst rd_req_ready", {31'd0, rd_req_ready}, 32'd0);
        check("rst rd_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        check("rst wb_ready", {31'd0, wb_ready}, 32'd0);
        check("rst rsp_data1", rd_rsp_data1, 32'd0);
        check("rst rsp_data2", rd_rsp_data2, 32'd0);
        check("rst rf_sel1", {27'd0, rf_sel1}, 32'd0);
        check("rst rf_sel2", {27'd0, rf_sel2}, 32'd0);
        check("rst rf_read_sel", {31'd0, rf_read_sel}, 32'd0);
        check("rst rf_write_sel", {31'd0, rf_write_sel}, 32'd0);
        check("rst rf_sel_write", {27'd0, rf_sel_write}, 32'd0);
        check("rst rf_data_write", rf_data_write, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release pre-edge wb_ready", {31'd0, wb_ready}, 32'd0);
        check("release pre-edge rd_req_ready", {31'd0, rd_req_ready}, 32'd0);
        @(posedge clk); #1;
        check("release wb_ready", {31'd0, wb_ready}, 32'd1);
        check("release rd_req_ready", {31'd0, rd_req_ready}, 32'd1);

        foreach (wvecs[i]) do_write(wvecs[i]);
        foreach (rvecs[i]) do_read(rvecs[i], i);

        // Reset during CAPTURE: pending read is dropped and the FSM restarts cleanly.
        rd_req_valid = 1'b1; rd_req_src1 = 5'd3; rd_req_src2 = 5'd5;
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        check("midrst req_ready", {31'd0, rd_req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst held rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        check("midrst held read_sel", {31'd0, rf_read_sel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst post req_ready", {31'd0, rd_req_ready}, 32'd1);
        check("midrst post rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        check("midrst post rsp_data1", rd_rsp_data1, 32'd0);
        rv = '{5'd3, 5'd26, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 32'h5555, 32'h2A4};
        do_read(rv, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
